mem_responder: RTL and testbench

Memory-side end of the proc2mem/mem2proc bus used by the D-cache MSHR. The block accepts BUS_LOAD and BUS_STORE commands and assigns a transaction tag on mem2proc_response in the same cycle. After a fixed latency it returns load data on mem2proc_tag/mem2proc_data. It holds a word-addressed backing store and serves as the synthesizable memory model for cache/MSHR integration benches.

---
 rtl/mem_responder.sv | 149 ++++++++++++++
 tb/tb_mem_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory end of the proc2mem/mem2proc bus with a word-addressed backing store.
// Latency: the tag is returned combinationally on mem2proc_response; load data returns MEM_LATENCY cycles after acceptance.
// Backpressure: a command is refused (response 0) when no tag is free; the requester retries.
//
// Ports:
//   clock, reset           - single clock, synchronous active-high reset
//   proc2mem_command/addr/data - request (0 none, 1 load, 2 store, 3 ignored); addr[3 +: MEM_ADDR_BITS] is the word index
//   mem2proc_response      - combinational tag for this cycle's command, 0 = refused / no command
//   mem2proc_tag/data      - registered load completion, both 0 when no load completes
//
// Optional build macro MEM_STALL_INJECT_EN: an 8-bit LFSR refuses commands whenever lfsr[2:0] == 0.
module mem_responder #(
    parameter int NUM_TAGS      = 15,
    parameter int MEM_LATENCY   = 10,
    parameter int MEM_ADDR_BITS = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2mem_command,
    input  logic [63:0] proc2mem_addr,
    input  logic [63:0] proc2mem_data,
    output logic [3:0]  mem2proc_response,
    output logic [63:0] mem2proc_data,
    output logic [3:0]  mem2proc_tag
);
    localparam int CW    = $clog2(MEM_LATENCY + 1);
    localparam int DEPTH = 1 << MEM_ADDR_BITS;
    localparam logic [1:0]    BUS_LOAD  = 2'd1;
    localparam logic [1:0]    BUS_STORE = 2'd2;
    localparam logic [CW-1:0] LAT       = CW'(MEM_LATENCY);
    localparam logic [CW-1:0] ONE       = CW'(1);

    logic [63:0]         mem [DEPTH];
    logic [NUM_TAGS-1:0] busy, busy_n, is_load, is_load_n;
    logic [CW-1:0]       cnt [NUM_TAGS];
    logic [CW-1:0]       cnt_n [NUM_TAGS];
    logic [63:0]         snap [NUM_TAGS];
    logic [63:0]         snap_n [NUM_TAGS];

    logic [MEM_ADDR_BITS-1:0] widx;
    logic [63:0]              rd_word;
    logic                     cmd_ok, free_found, stall, accept;
    logic [3:0]               free_idx;
    logic [3:0]               ret_tag_n;
    logic [63:0]              ret_dat_n;
    logic                     unused_addr;

    // Byte offset and bits above the store depth are ignored, so addresses wrap.
    assign widx        = proc2mem_addr[3 +: MEM_ADDR_BITS];
    assign unused_addr = ^{proc2mem_addr[63:3+MEM_ADDR_BITS], proc2mem_addr[2:0]};
    assign rd_word     = mem[widx];
    assign cmd_ok      = (proc2mem_command == BUS_LOAD) || (proc2mem_command == BUS_STORE);

`ifdef MEM_STALL_INJECT_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, taps 8,6,5,4.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign stall = (lfsr[2:0] == 3'b000);
`else
    assign stall = 1'b0;
`endif

    // Lowest-numbered free tag: scan downward so the lowest index wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = 4'd0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = 4'(i);
            end
        end
    end

    assign accept            = !reset && cmd_ok && free_found && !stall;
    assign mem2proc_response = accept ? (free_idx + 4'd1) : 4'd0;

    // Next tag state. A tag whose counter is 1 is in its return cycle and frees at this edge,
    // so its busy bit still blocks reuse during that cycle.
    always_comb begin
        busy_n    = busy;
        is_load_n = is_load;
        ret_tag_n = 4'd0;
        ret_dat_n = 64'd0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            cnt_n[i]  = cnt[i];
            snap_n[i] = snap[i];
            if (busy[i]) begin
                if (cnt[i] <= ONE) begin
                    busy_n[i] = 1'b0;
                    cnt_n[i]  = '0;
                end else begin
                    cnt_n[i] = cnt[i] - ONE;
                end
            end
            if (accept && (free_idx == 4'(i))) begin
                busy_n[i]    = 1'b1;
                is_load_n[i] = (proc2mem_command == BUS_LOAD);
                cnt_n[i]     = LAT;
                if (proc2mem_command == BUS_LOAD) begin
                    snap_n[i] = rd_word;
                end
            end
        end
        // The registered return reflects whichever load reaches its final cycle next.
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (busy_n[i] && is_load_n[i] && (cnt_n[i] == ONE)) begin
                ret_tag_n = 4'(i + 1);
                ret_dat_n = snap_n[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy          <= '0;
            is_load       <= '0;
            mem2proc_tag  <= 4'd0;
            mem2proc_data <= 64'd0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                cnt[i]  <= '0;
                snap[i] <= 64'd0;
            end
            for (int j = 0; j < DEPTH; j++) begin
                mem[j] <= 64'd0;
            end
        end else begin
            busy          <= busy_n;
            is_load       <= is_load_n;
            mem2proc_tag  <= ret_tag_n;
            mem2proc_data <= ret_dat_n;
            for (int i = 0; i < NUM_TAGS; i++) begin
                cnt[i]  <= cnt_n[i];
                snap[i] <= snap_n[i];
            end
            if (accept && (proc2mem_command == BUS_STORE)) begin
                mem[widx] <= proc2mem_data;
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
module tb_mem_responder;
    localparam int LAT  = 10;
    localparam int NT   = 15;
    localparam int AB   = 10;
    localparam int LAT2 = 4;
    localparam int NT2  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cmd   = 2'd0;
    logic [63:0] addr  = 64'd0;
    logic [63:0] wdat  = 64'd0;
    logic [3:0]  resp, tag, resp2, tag2;
    logic [63:0] rdat, rdat2;

    mem_responder #(.NUM_TAGS(NT), .MEM_LATENCY(LAT), .MEM_ADDR_BITS(AB)) dut (
        .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
        .proc2mem_data(wdat), .mem2proc_response(resp), .mem2proc_data(rdat), .mem2proc_tag(tag));

    // Small instance so tag exhaustion is reachable.
    mem_responder #(.NUM_TAGS(NT2), .MEM_LATENCY(LAT2), .MEM_ADDR_BITS(AB)) dut2 (
        .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
        .proc2mem_data(wdat), .mem2proc_response(resp2), .mem2proc_data(rdat2), .mem2proc_tag(tag2));

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: per-tag "free from cycle" times, a list of scheduled returns, sparse memory.
    typedef struct { int due; logic [3:0] t; logic [63:0] d; } pend_t;
    pend_t       pend[$];
    logic [63:0] mmem [int];
    int          free_at [NT+1];
    bit          model_ok = 1'b0;
    logic [7:0]  m_lfsr   = 8'hA5;
    logic [3:0]  s_resp, s_tag, s2_resp, s2_tag;
    logic [63:0] s_dat;

    task automatic do_cycle(input logic r, input logic [1:0] c, input logic [63:0] a, input logic [63:0] d);
        logic [3:0]  e_resp, e_tag;
        logic [63:0] e_dat;
        bit          stall;
        int          w;
        reset = r; cmd = c; addr = a; wdat = d;
        @(negedge clock);
        s_resp = resp; s_tag = tag; s_dat = rdat; s2_resp = resp2; s2_tag = tag2;
        e_tag = 4'd0;
        e_dat = 64'd0;
        foreach (pend[k]) if (pend[k].due == cyc) begin
            e_tag = pend[k].t;
            e_dat = pend[k].d;
        end
`ifdef MEM_STALL_INJECT_EN
        stall = (m_lfsr[2:0] == 3'b000);
`else
        stall = 1'b0;
`endif
        e_resp = 4'd0;
        if (!r && (c == 2'd1 || c == 2'd2) && !stall)
            for (int t = NT; t >= 1; t--) if (free_at[t] <= cyc) e_resp = 4'(t);
        check("model_resp", {60'd0, s_resp}, {60'd0, e_resp});
        if (model_ok) begin
            check("model_tag", {60'd0, s_tag}, {60'd0, e_tag});
            check("model_data", s_dat, e_dat);
        end
        w = int'(a[3 +: AB]);
        if (r) begin
            pend.delete();
            mmem.delete();
            foreach (free_at[t]) free_at[t] = 0;
            model_ok = 1'b1;
            m_lfsr   = 8'hA5;
        end else begin
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            if (e_resp != 4'd0) begin
                free_at[e_resp] = cyc + LAT + 1;
                if (c == 2'd1) pend.push_back('{cyc + LAT, e_resp, mmem.exists(w) ? mmem[w] : 64'd0});
                else           mmem[w] = d;
            end
        end
        while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
        cyc++;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [1:0]  c;
        logic [63:0] a, d;
        logic [3:0]  resp, tag;
        logic [63:0] dat;
    } vec_t;

    localparam logic [63:0] D1 = 64'h1122334455667788;
    localparam logic [63:0] D2 = 64'h00000000CAFEF00D;

    initial begin
        vec_t   tbl [24];
        logic [3:0] e2_resp [15];
        logic [3:0] e2_tag  [15];
        logic [1:0] rc;

        for (int i = 0; i < 24; i++) tbl[i] = '{2'd0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0};
        tbl[0]  = '{2'd2, 64'h40,   D1,          4'd1, 4'd0, 64'd0};  // store word 8
        tbl[1]  = '{2'd1, 64'h40,   64'd0,       4'd2, 4'd0, 64'd0};  // load sees the store
        tbl[2]  = '{2'd2, 64'h0,    D2,          4'd3, 4'd0, 64'd0};  // store word 0
        tbl[3]  = '{2'd3, 64'h0,    64'hDEAD,    4'd0, 4'd0, 64'd0};  // ignored command, no write
        tbl[11] = '{2'd1, 64'h47,   64'd0,       4'd1, 4'd2, D1};     // tag 1 free again; alias to word 8
        tbl[12] = '{2'd1, 64'h2000, 64'd0,       4'd2, 4'd0, 64'd0};  // bit 13 wraps to word 0
        tbl[21] = '{2'd0, 64'h0,    64'd0,       4'd0, 4'd1, D1};
        tbl[22] = '{2'd0, 64'h0,    64'd0,       4'd0, 4'd2, D2};

        e2_resp = '{4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0};
        e2_tag  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd1};

        do_cycle(1'b1, 2'd0, 64'd0, 64'd0);
        do_cycle(1'b1, 2'd0, 64'd0, 64'd0);

`ifndef MEM_STALL_INJECT_EN
        // Directed vectors: store/load ordering, aliasing, silent store completion.
        for (int i = 0; i < 24; i++) begin
            do_cycle(1'b0, tbl[i].c, tbl[i].a, tbl[i].d);
            check($sformatf("tbl_resp[%0d]", i), {60'd0, s_resp}, {60'd0, tbl[i].resp});
            check($sformatf("tbl_tag[%0d]", i),  {60'd0, s_tag},  {60'd0, tbl[i].tag});
            check($sformatf("tbl_data[%0d]", i), s_dat, tbl[i].dat);
        end

        // Back-to-back loads: tag reuse on the big instance, exhaustion on the small one.
        do_cycle(1'b1, 2'd0, 64'd0, 64'd0);
        for (int i = 0; i < 15; i++) begin
            do_cycle(1'b0, 2'd1, 64'(i * 8), 64'd0);
            check($sformatf("b2b_resp[%0d]", i), {60'd0, s_resp}, 64'((i <= 10) ? i + 1 : i - 10));
            check($sformatf("small_resp[%0d]", i), {60'd0, s2_resp}, {60'd0, e2_resp[i]});
            check($sformatf("small_tag[%0d]", i),  {60'd0, s2_tag},  {60'd0, e2_tag[i]});
        end

        // Reset while loads are in flight: nothing returns afterwards, memory is cleared.
        do_cycle(1'b1, 2'd0, 64'd0, 64'd0);
        do_cycle(1'b0, 2'd2, 64'h28, 64'h55AA55AA);
        for (int i = 1; i <= 3; i++) begin
            do_cycle(1'b0, 2'd1, 64'h28, 64'd0);
            check($sformatf("pre_rst_resp[%0d]", i), {60'd0, s_resp}, 64'(i + 1));
        end
        do_cycle(1'b0, 2'd0, 64'd0, 64'd0);
        do_cycle(1'b1, 2'd0, 64'd0, 64'd0);
        for (int i = 6; i <= 30; i++) begin
            do_cycle(1'b0, 2'd0, 64'd0, 64'd0);
            check($sformatf("post_rst_tag[%0d]", i), {60'd0, s_tag}, 64'd0);
        end
        do_cycle(1'b0, 2'd1, 64'h28, 64'd0);
        check("post_rst_resp", {60'd0, s_resp}, 64'd1);
        for (int i = 32; i <= 41; i++) do_cycle(1'b0, 2'd0, 64'd0, 64'd0);
        check("post_rst_ret_tag", {60'd0, s_tag}, 64'd1);
        check("post_rst_ret_data", s_dat, 64'd0);
`endif

        // Randomized traffic against the model, with occasional resets.
        do_cycle(1'b1, 2'd0, 64'd0, 64'd0);
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] a;
            rc = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) rc = 2'd0;
            a = {$urandom, $urandom};
            a[3 +: AB] = AB'($urandom_range(0, 15));
            do_cycle(($urandom_range(0, 299) == 0), rc, a, {$urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
